// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button conditioning path.
// Clock rate and the 50 ms debounce default live here so other pin inputs agree.
package button_debouncer_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DEBOUNCE_50MS = CLK_HZ / 20;

    typedef enum logic [1:0] {
        REL_STABLE = 2'd0,
        PRESS_WAIT = 2'd1,
        PRS_STABLE = 2'd2,
        REL_WAIT   = 2'd3
    } debounce_state_t;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset to 0.
// Shared by every asynchronous pin input, not only the button.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus one-cycle press/release pulses.
// Optional macro BTN_DEBOUNCE_PRESS_CNT_EN adds an 8-bit wrapping press_count output.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MS,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_rise,
    output logic       btn_fall
`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic            btn_pressed;
    logic            s2;
    debounce_state_t state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            level_n, rise_n, fall_n;

    assign btn_pressed = btn_raw ^ ACTIVE_LOW;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_pressed),
        .q     (s2)
    );

    // cnt holds how many consecutive cycles s2 has disagreed with the accepted
    // level, including the cycle that left the STABLE state; reaching
    // DEBOUNCE_CYCLES accepts the new level.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = btn_level;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            REL_STABLE: begin
                cnt_n = '0;
                if (s2) begin
                    if (CNT_ONE == CNT_MAX) begin
                        state_n = PRS_STABLE;
                        level_n = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        state_n = PRESS_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = REL_STABLE;
                    cnt_n   = '0;
                end else if ((cnt + CNT_ONE) == CNT_MAX) begin
                    state_n = PRS_STABLE;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            PRS_STABLE: begin
                cnt_n = '0;
                if (!s2) begin
                    if (CNT_ONE == CNT_MAX) begin
                        state_n = REL_STABLE;
                        level_n = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        state_n = REL_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            REL_WAIT: begin
                if (s2) begin
                    state_n = PRS_STABLE;
                    cnt_n   = '0;
                end else if ((cnt + CNT_ONE) == CNT_MAX) begin
                    state_n = REL_STABLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = REL_STABLE;
                cnt_n   = '0;
                level_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REL_STABLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            btn_level <= level_n;
            btn_rise  <= rise_n;
            btn_fall  <= fall_n;
        end
    end

`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
    // Steps on the same edge that raises btn_rise; wraps 255 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= 8'd0;
        end else if (rise_n) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw mechanical push-button into a clean, glitch-free level plus single-cycle edge pulses. It sits directly upstream of the reset-hold stage and of every keypad/button consumer, feeding them a stable, clock-synchronous signal instead of the bouncing pin. It is built from a 2-flop synchronizer, a stability counter and a 4-state debounce FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 2_500_000: cycles the synchronized input must stay stable before it is accepted (50 ms at 50 MHz); legal range ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed (input is inverted before the synchronizer); 0 means the pin reads 1 when pressed.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_raw`  in  1  asynchronous physical button pin.
- `btn_level`  out  1  debounced pressed state; 1 means pressed.
- `btn_rise`  out  1  one-cycle pulse on each accepted press.
- `btn_fall`  out  1  one-cycle pulse on each accepted release.
- `press_count`  out  8  accepted-press counter; present only with `BTN_DEBOUNCE_PRESS_CNT_EN`.

## Operation
- **Polarity:** `btn_raw` is XORed with `ACTIVE_LOW`, then passed through sync flops `s1` → `s2`. `s2` is the FSM input.
- **States:** `REL_STABLE`, `PRESS_WAIT`, `PRS_STABLE`, `REL_WAIT`.
- **Counter:** width is `$clog2(DEBOUNCE_CYCLES+1)`; it is zero in both STABLE states.
- **From `REL_STABLE`:**
  - If `s2` = 1, go to `PRESS_WAIT` with count = 1.
- **From `PRESS_WAIT`:**
  - If `s2` = 0, return to `REL_STABLE` and clear the count. A bounce restarts qualification.
  - Else, if count = `DEBOUNCE_CYCLES`, go to `PRS_STABLE`, set `btn_level` = 1 and pulse `btn_rise`.
  - Else, increment the count.
- **From `PRS_STABLE` / `REL_WAIT`:** mirror the press path with the polarity reversed. Acceptance clears `btn_level` and pulses `btn_fall`.
- **Output registering:** `btn_rise` and `btn_fall` are registered. They are high for exactly one cycle, in the same cycle `btn_level` first shows its new value, and are never both high.
- **Reset:** all flops clear, the state goes to `REL_STABLE`, and all outputs are 0.
  - A button held through reset deassertion is qualified as a fresh press and produces one `btn_rise`. This is intentional.
- **Reset mid-qualification:** the partial count is discarded and no pulse is emitted.
- **Counter saturation:** the counter never exceeds `DEBOUNCE_CYCLES` and never wraps.

## Timing
- **Press latency:** `btn_raw` changes and stays stable, first sampled at edge k. `s2` reflects the change after edge k+1. `btn_level` and the pulse update after edge k+1+`DEBOUNCE_CYCLES`. Release latency is the same.
- **Bounce rejection:** a glitch on `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- **Minimum spacing:** back-to-back accepted edges are at least `DEBOUNCE_CYCLES` cycles apart.

## Configuration
- **`BTN_DEBOUNCE_PRESS_CNT_EN` defined:**
  - Adds the `press_count` port: 8-bit, reset to 0, incremented in the cycle `btn_rise` is asserted.
  - Wraps 255 → 0.
  - Intended for bench and board diagnostics.
- **Not defined:**
  - The port and the counter are absent.
  - Behaviour of all other outputs is identical.

## Structure
- **Shared utils package:**
  - enum `debounce_state_t` holding the four states.
  - Localparam `CLK_HZ` = 50_000_000.
  - Helper constant `DEBOUNCE_50MS` = `CLK_HZ`/20.
- **Sub-module `sync_2ff`:** the generic 2-flop synchronizer, 1 bit, reset value 0. It is reused by other pin inputs.
- **Top-level contents:** the FSM, the counter and the output registers stay in `button_debouncer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `ACTIVE_LOW` = 0.
- **Clean press:** `btn_raw` 0→1 held 20 cycles → `btn_level` rises 5 edges after first sampling; `btn_rise` high for exactly 1 cycle; `btn_fall` stays 0.
- **Bounce:** `btn_raw` toggles 1,0,1,0,1 every 2 cycles, then holds 1 → exactly one `btn_rise`, 5 edges after the final 0→1 sample; `btn_level` never toggles early.
- **Release:** from the pressed state, `btn_raw` → 0 held → `btn_level` falls after 5 edges; one `btn_fall` pulse.
- **Reset mid-qualification:** `reset` asserted 2 cycles into `PRESS_WAIT` → outputs 0, no pulse. With `btn_raw` still 1 after deassert → `btn_rise` follows after a full fresh qualification.
- **Polarity:** `ACTIVE_LOW` = 1, `btn_raw` idles at 1, press drives it to 0 → `btn_level` = 1 and `btn_rise` pulses after 5 edges.
- **Press counter:** with `BTN_DEBOUNCE_PRESS_CNT_EN`, 257 clean presses → `press_count` = 1 (wrapped); count unaffected by bounces or releases.
